// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the two-port memory arbiter: word type, FSM states, port ids
// and the A/B selection rule.
package mem_port_arbiter_pkg;

   typedef logic [15:0] lc3b_word;

   typedef enum logic [1:0] {
      ARB_IDLE   = 2'd0,
      ARB_BUSY_A = 2'd1,
      ARB_BUSY_B = 2'd2
   } arb_state_t;

   typedef enum logic {
      PORT_A = 1'b0,
      PORT_B = 1'b1
   } arb_port_t;

   // On a tie, round-robin hands the port to whoever did not win last; fixed priority favours A.
   function automatic arb_port_t pick_winner(input logic      req_a,
                                             input logic      req_b,
                                             input arb_port_t last_grant,
                                             input logic      rr_en);
      arb_port_t w;
      if (req_a && req_b) begin
         w = (rr_en && last_grant == PORT_A) ? PORT_B : PORT_A;
      end else begin
         w = req_a ? PORT_A : PORT_B;
      end
      return w;
   endfunction

endpackage

// File: rtl/mem_port_arbiter_req_latch.sv
// Holds the winning request while it is presented to memory; load captures a new
// request, clear drops only the strobes so address/data stay stable.
module mem_req_latch #(
   parameter int ADDR_W = 16,
   parameter int DATA_W = 16,
   parameter int MASK_W = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              load,
   input  logic              clear,
   input  logic              read_in,
   input  logic              write_in,
   input  logic [MASK_W-1:0] wmask_in,
   input  logic [ADDR_W-1:0] address_in,
   input  logic [DATA_W-1:0] wdata_in,
   output logic              read_q,
   output logic              write_q,
   output logic [MASK_W-1:0] wmask_q,
   output logic [ADDR_W-1:0] address_q,
   output logic [DATA_W-1:0] wdata_q
);

   logic              read_d;
   logic              write_d;
   logic [MASK_W-1:0] wmask_d;
   logic [ADDR_W-1:0] address_d;
   logic [DATA_W-1:0] wdata_d;

   // A request with both strobes set is treated as a write.
   always_comb begin
      read_d    = read_q;
      write_d   = write_q;
      wmask_d   = wmask_q;
      address_d = address_q;
      wdata_d   = wdata_q;
      if (load) begin
         read_d    = read_in & ~write_in;
         write_d   = write_in;
         wmask_d   = wmask_in;
         address_d = address_in;
         wdata_d   = wdata_in;
      end else if (clear) begin
         read_d  = 1'b0;
         write_d = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         read_q    <= 1'b0;
         write_q   <= 1'b0;
         wmask_q   <= '0;
         address_q <= '0;
         wdata_q   <= '0;
      end else begin
         read_q    <= read_d;
         write_q   <= write_d;
         wmask_q   <= wmask_d;
         address_q <= address_d;
         wdata_q   <= wdata_d;
      end
   end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch (A) and data (B); the winner's
// request is latched at grant and held until mem_resp.
module mem_port_arbiter
   import mem_port_arbiter_pkg::*;
#(
   parameter int ADDR_W = 16,
   parameter int DATA_W = 16,
   parameter int MASK_W = 2,
   parameter int RR_EN  = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              read_a,
   input  logic              write_a,
   input  logic [MASK_W-1:0] wmask_a,
   input  logic [ADDR_W-1:0] address_a,
   input  logic [DATA_W-1:0] wdata_a,
   output logic              resp_a,
   output logic [DATA_W-1:0] rdata_a,
   input  logic              read_b,
   input  logic              write_b,
   input  logic [MASK_W-1:0] wmask_b,
   input  logic [ADDR_W-1:0] address_b,
   input  logic [DATA_W-1:0] wdata_b,
   output logic              resp_b,
   output logic [DATA_W-1:0] rdata_b,
   output logic              mem_read,
   output logic              mem_write,
   output logic [MASK_W-1:0] mem_wmask,
   output logic [ADDR_W-1:0] mem_address,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic              mem_resp,
   input  logic [DATA_W-1:0] mem_rdata
);

   arb_state_t        state_q, state_d;
   arb_port_t         last_q, last_d;
   arb_port_t         winner;
   logic              req_a, req_b;
   logic              load, clear;
   logic              sel_read, sel_write;
   logic [MASK_W-1:0] sel_wmask;
   logic [ADDR_W-1:0] sel_address;
   logic [DATA_W-1:0] sel_wdata;

   // Grants only happen from IDLE, which forces one idle cycle between transactions.
   always_comb begin
      req_a   = read_a | write_a;
      req_b   = read_b | write_b;
      winner  = pick_winner(req_a, req_b, last_q, RR_EN != 0);
      state_d = state_q;
      last_d  = last_q;
      load    = 1'b0;
      clear   = 1'b0;
      case (state_q)
         ARB_IDLE: begin
            if (req_a || req_b) begin
               load    = 1'b1;
               last_d  = winner;
               state_d = (winner == PORT_A) ? ARB_BUSY_A : ARB_BUSY_B;
            end
         end
         ARB_BUSY_A, ARB_BUSY_B: begin
            if (mem_resp) begin
               clear   = 1'b1;
               state_d = ARB_IDLE;
            end
         end
         default: state_d = ARB_IDLE;
      endcase
   end

   assign sel_read    = (winner == PORT_B) ? read_b    : read_a;
   assign sel_write   = (winner == PORT_B) ? write_b   : write_a;
   assign sel_wmask   = (winner == PORT_B) ? wmask_b   : wmask_a;
   assign sel_address = (winner == PORT_B) ? address_b : address_a;
   assign sel_wdata   = (winner == PORT_B) ? wdata_b   : wdata_a;

   // Reset leaves last grant on B so that A wins the very first tie.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ARB_IDLE;
         last_q  <= PORT_B;
      end else begin
         state_q <= state_d;
         last_q  <= last_d;
      end
   end

   mem_req_latch #(
      .ADDR_W(ADDR_W),
      .DATA_W(DATA_W),
      .MASK_W(MASK_W)
   ) u_req_latch (
      .clk       (clk),
      .rst       (rst),
      .load      (load),
      .clear     (clear),
      .read_in   (sel_read),
      .write_in  (sel_write),
      .wmask_in  (sel_wmask),
      .address_in(sel_address),
      .wdata_in  (sel_wdata),
      .read_q    (mem_read),
      .write_q   (mem_write),
      .wmask_q   (mem_wmask),
      .address_q (mem_address),
      .wdata_q   (mem_wdata)
   );

   assign resp_a  = mem_resp & (state_q == ARB_BUSY_A);
   assign resp_b  = mem_resp & (state_q == ARB_BUSY_B);
   assign rdata_a = mem_rdata;
   assign rdata_b = mem_rdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Drives a round-robin instance (index 0) and a fixed-priority instance (index 1)
// with directed and random requester/memory traffic against a transaction model.
module tb_mem_port_arbiter;
   import mem_port_arbiter_pkg::*;

   typedef struct {
      logic      rd;
      logic      wr;
      lc3b_word  addr;
      lc3b_word  wdata;
      logic [1:0] mask;
   } req_t;

   logic       clk, rst;
   logic       read_a[2], write_a[2], read_b[2], write_b[2];
   logic       resp_a[2], resp_b[2], mem_read[2], mem_write[2], mem_resp[2];
   logic [1:0] wmask_a[2], wmask_b[2], mem_wmask[2];
   lc3b_word   address_a[2], wdata_a[2], rdata_a[2];
   lc3b_word   address_b[2], wdata_b[2], rdata_b[2];
   lc3b_word   mem_address[2], mem_wdata[2], mem_rdata[2];

   int       checks, errors;
   req_t     rq[2][2];
   bit       pend[2][2];
   bit       rearm[2][2];
   int       m_busy[2];
   int       m_last[2];
   req_t     m_req[2];
   int       m_cnt[2], m_lim[2];
   int       lat_fix;
   bit       rdata_fix_en;
   lc3b_word rdata_fix;
   bit       rnd_spawn, churn;
   int       obs_log[$];

   mem_port_arbiter #(.ADDR_W(16), .DATA_W(16), .MASK_W(2), .RR_EN(1)) u_rr (
      .clk(clk), .rst(rst),
      .read_a(read_a[0]), .write_a(write_a[0]), .wmask_a(wmask_a[0]),
      .address_a(address_a[0]), .wdata_a(wdata_a[0]),
      .resp_a(resp_a[0]), .rdata_a(rdata_a[0]),
      .read_b(read_b[0]), .write_b(write_b[0]), .wmask_b(wmask_b[0]),
      .address_b(address_b[0]), .wdata_b(wdata_b[0]),
      .resp_b(resp_b[0]), .rdata_b(rdata_b[0]),
      .mem_read(mem_read[0]), .mem_write(mem_write[0]), .mem_wmask(mem_wmask[0]),
      .mem_address(mem_address[0]), .mem_wdata(mem_wdata[0]),
      .mem_resp(mem_resp[0]), .mem_rdata(mem_rdata[0])
   );

   mem_port_arbiter #(.ADDR_W(16), .DATA_W(16), .MASK_W(2), .RR_EN(0)) u_fp (
      .clk(clk), .rst(rst),
      .read_a(read_a[1]), .write_a(write_a[1]), .wmask_a(wmask_a[1]),
      .address_a(address_a[1]), .wdata_a(wdata_a[1]),
      .resp_a(resp_a[1]), .rdata_a(rdata_a[1]),
      .read_b(read_b[1]), .write_b(write_b[1]), .wmask_b(wmask_b[1]),
      .address_b(address_b[1]), .wdata_b(wdata_b[1]),
      .resp_b(resp_b[1]), .rdata_b(rdata_b[1]),
      .mem_read(mem_read[1]), .mem_write(mem_write[1]), .mem_wmask(mem_wmask[1]),
      .mem_address(mem_address[1]), .mem_wdata(mem_wdata[1]),
      .mem_resp(mem_resp[1]), .mem_rdata(mem_rdata[1])
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not finish in time");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic req_t rand_req();
      req_t r;
      r.rd    = 1'($urandom_range(0, 1));
      r.wr    = ~r.rd;
      r.addr  = lc3b_word'($urandom);
      r.wdata = lc3b_word'($urandom);
      r.mask  = 2'($urandom_range(0, 3));
      return r;
   endfunction

   function automatic req_t mk_req(input logic rd, input logic wr, input lc3b_word addr,
                                   input lc3b_word wdata, input logic [1:0] mask);
      req_t r;
      r.rd = rd; r.wr = wr; r.addr = addr; r.wdata = wdata; r.mask = mask;
      return r;
   endfunction

   task automatic drive(input int d);
      read_a[d]    = pend[d][0] & rq[d][0].rd;
      write_a[d]   = pend[d][0] & rq[d][0].wr;
      address_a[d] = rq[d][0].addr;
      wdata_a[d]   = rq[d][0].wdata;
      wmask_a[d]   = rq[d][0].mask;
      read_b[d]    = pend[d][1] & rq[d][1].rd;
      write_b[d]   = pend[d][1] & rq[d][1].wr;
      address_b[d] = rq[d][1].addr;
      wdata_b[d]   = rq[d][1].wdata;
      wmask_b[d]   = rq[d][1].mask;
   endtask

   // One clock of requesters + memory for instance d, checked against the model.
   task automatic apply_stimulus(input int d);
      logic mresp;
      int   w;
      @(negedge clk);
      mresp = 1'b0;
      if (m_busy[d] != 0) begin
         m_cnt[d]++;
         mresp = (m_cnt[d] >= m_lim[d]);
      end else if (rnd_spawn) begin
         mresp = ($urandom_range(0, 7) == 0);
      end
      mem_resp[d]  = mresp;
      mem_rdata[d] = rdata_fix_en ? rdata_fix : lc3b_word'($urandom);
      if (churn) begin
         for (int p = 0; p < 2; p++) begin
            if (pend[d][p]) rq[d][p] = rand_req();
            if (m_busy[d] == p + 1 && $urandom_range(0, 3) == 0) pend[d][p] = 1'b0;
         end
      end
      drive(d);
      #1;
      check_output("mem_read",  mem_read[d],  (m_busy[d] != 0) && m_req[d].rd);
      check_output("mem_write", mem_write[d], (m_busy[d] != 0) && m_req[d].wr);
      if (m_busy[d] != 0) begin
         check_output("mem_address", mem_address[d], m_req[d].addr);
         check_output("mem_wdata",   mem_wdata[d],   m_req[d].wdata);
         check_output("mem_wmask",   mem_wmask[d],   m_req[d].mask);
      end
      check_output("resp_a", resp_a[d], mresp && m_busy[d] == 1);
      check_output("resp_b", resp_b[d], mresp && m_busy[d] == 2);
      if (mresp && m_busy[d] == 1) check_output("rdata_a", rdata_a[d], mem_rdata[d]);
      if (mresp && m_busy[d] == 2) check_output("rdata_b", rdata_b[d], mem_rdata[d]);
      if (resp_a[d] === 1'b1) obs_log.push_back(0);
      if (resp_b[d] === 1'b1) obs_log.push_back(1);
      // Model of the coming edge: finish the transaction, or hand out the port.
      if (m_busy[d] != 0 && mresp) begin
         if (!rearm[d][m_busy[d] - 1]) pend[d][m_busy[d] - 1] = 1'b0;
         m_busy[d] = 0;
      end else if (m_busy[d] == 0 && (pend[d][0] || pend[d][1])) begin
         if (pend[d][0] && pend[d][1]) w = (d == 0 && m_last[d] == 0) ? 1 : 0;
         else                          w = pend[d][0] ? 0 : 1;
         m_req[d]    = rq[d][w];
         m_req[d].rd = rq[d][w].rd & ~rq[d][w].wr;
         m_busy[d]   = w + 1;
         m_last[d]   = w;
         m_cnt[d]    = 0;
         m_lim[d]    = (lat_fix != 0) ? lat_fix : $urandom_range(1, 3);
      end
      if (rnd_spawn) begin
         for (int p = 0; p < 2; p++) begin
            if (!pend[d][p] && m_busy[d] != p + 1 && $urandom_range(0, 1) == 1) begin
               pend[d][p] = 1'b1;
               rq[d][p]   = rand_req();
            end
         end
      end
   endtask

   task automatic async_reset();
      #2;
      rst = 1'b1;
      mem_resp[0] = 1'b1;
      mem_resp[1] = 1'b1;
      #1;
      for (int d = 0; d < 2; d++) begin
         check_output("rst_mem_read",    mem_read[d],    0);
         check_output("rst_mem_write",   mem_write[d],   0);
         check_output("rst_mem_address", mem_address[d], 0);
         check_output("rst_mem_wdata",   mem_wdata[d],   0);
         check_output("rst_mem_wmask",   mem_wmask[d],   0);
         check_output("rst_resp_a",      resp_a[d],      0);
         check_output("rst_resp_b",      resp_b[d],      0);
      end
      for (int d = 0; d < 2; d++) begin
         m_busy[d] = 0;
         m_last[d] = 1;
         m_req[d]  = mk_req(1'b0, 1'b0, '0, '0, '0);
         for (int p = 0; p < 2; p++) begin
            pend[d][p]  = 1'b0;
            rearm[d][p] = 1'b0;
         end
         mem_resp[d]  = 1'b0;
         mem_rdata[d] = '0;
         drive(d);
      end
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic drain(input int d);
      rnd_spawn = 1'b0;
      churn     = 1'b0;
      rearm[d][0] = 1'b0;
      rearm[d][1] = 1'b0;
      for (int i = 0; i < 60; i++) begin
         apply_stimulus(d);
         if (m_busy[d] == 0 && !pend[d][0] && !pend[d][1]) break;
      end
      apply_stimulus(d);
   endtask

   task automatic wait_resps(input int d, input int n, input string tag);
      for (int i = 0; i < 80 && obs_log.size() < n; i++) apply_stimulus(d);
      check_output(tag, obs_log.size(), n);
   endtask

   initial begin
      checks = 0; errors = 0;
      rst = 1'b0;
      lat_fix = 0; rdata_fix_en = 1'b0; rdata_fix = '0;
      rnd_spawn = 1'b0; churn = 1'b0;
      for (int d = 0; d < 2; d++) begin
         for (int p = 0; p < 2; p++) rq[d][p] = mk_req(1'b0, 1'b0, '0, '0, '0);
      end

      // Asynchronous reset from an unknown start, mid-cycle.
      async_reset();

      // Lone read on A with a three-cycle memory.
      lat_fix = 3; rdata_fix_en = 1'b1; rdata_fix = 16'hBEEF;
      obs_log.delete();
      rq[0][0] = mk_req(1'b1, 1'b0, 16'h1234, 16'h0000, 2'b00);
      pend[0][0] = 1'b1;
      wait_resps(0, 1, "a_read_resp_count");
      check_output("a_read_port", obs_log[0], 0);
      drain(0);

      // Lone write on B.
      obs_log.delete();
      rq[0][1] = mk_req(1'b0, 1'b1, 16'h4000, 16'h00AA, 2'b01);
      pend[0][1] = 1'b1;
      wait_resps(0, 1, "b_write_resp_count");
      check_output("b_write_port", obs_log[0], 1);
      drain(0);

      // Round-robin with both ports requesting continuously.
      lat_fix = 2; rdata_fix_en = 1'b0;
      obs_log.delete();
      rq[0][0] = mk_req(1'b1, 1'b0, 16'h0A00, 16'h0000, 2'b11);
      rq[0][1] = mk_req(1'b0, 1'b1, 16'h0B00, 16'h5555, 2'b10);
      pend[0][0] = 1'b1; pend[0][1] = 1'b1;
      rearm[0][0] = 1'b1; rearm[0][1] = 1'b1;
      wait_resps(0, 4, "rr_resp_count");
      for (int i = 0; i < 4; i++) check_output($sformatf("rr_grant%0d", i), obs_log[i], i % 2);
      drain(0);

      // Fixed priority: B only gets in once A stops asking.
      obs_log.delete();
      rq[1][0] = mk_req(1'b0, 1'b1, 16'h1A00, 16'h1111, 2'b11);
      rq[1][1] = mk_req(1'b1, 1'b0, 16'h1B00, 16'h0000, 2'b00);
      pend[1][0] = 1'b1; pend[1][1] = 1'b1;
      rearm[1][0] = 1'b1; rearm[1][1] = 1'b1;
      wait_resps(1, 3, "fp_resp_count");
      rearm[1][0] = 1'b0;
      wait_resps(1, 5, "fp_resp_count2");
      for (int i = 0; i < 4; i++) check_output($sformatf("fp_grant%0d", i), obs_log[i], 0);
      check_output("fp_grant4", obs_log[4], 1);
      drain(1);

      // Requester inputs churn (and may drop) while the port is busy.
      lat_fix = 4;
      rq[0][0] = mk_req(1'b1, 1'b0, 16'h0100, 16'h0000, 2'b00);
      pend[0][0] = 1'b1;
      churn = 1'b1;
      for (int i = 0; i < 12; i++) apply_stimulus(0);
      drain(0);

      // Both strobes high on A: the write takes precedence.
      obs_log.delete();
      rq[0][0] = mk_req(1'b1, 1'b1, 16'h2222, 16'h3333, 2'b11);
      pend[0][0] = 1'b1;
      wait_resps(0, 1, "rw_resp_count");
      drain(0);

      // Reset in BUSY_B aborts without a response, then A wins the next tie.
      lat_fix = 6;
      obs_log.delete();
      rq[0][1] = mk_req(1'b0, 1'b1, 16'h4444, 16'h0F0F, 2'b10);
      pend[0][1] = 1'b1;
      for (int i = 0; i < 3; i++) apply_stimulus(0);
      async_reset();
      check_output("abort_no_resp", obs_log.size(), 0);
      lat_fix = 2;
      rq[0][0] = mk_req(1'b1, 1'b0, 16'h5A5A, 16'h0000, 2'b00);
      rq[0][1] = mk_req(1'b1, 1'b0, 16'h6B6B, 16'h0000, 2'b00);
      pend[0][0] = 1'b1; pend[0][1] = 1'b1;
      wait_resps(0, 2, "rearb_resp_count");
      check_output("rearb_grant0", obs_log[0], 0);
      check_output("rearb_grant1", obs_log[1], 1);
      drain(0);

      // Random traffic on both instances, then with churn on the round-robin one.
      lat_fix = 0;
      for (int d = 0; d < 2; d++) begin
         rnd_spawn = 1'b1;
         for (int i = 0; i < 300; i++) apply_stimulus(d);
         drain(d);
      end
      rnd_spawn = 1'b1;
      churn = 1'b1;
      for (int i = 0; i < 150; i++) apply_stimulus(0);
      drain(0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
